// File: rtl/qspi_arb_if.sv
// Bundle between the line requesters (dcache, icache, aux), the QSPI engine and the arbiter.
// Requests are level-held until the matching grant; grant and q_req hold for the whole transfer; done/err/q_done are single-cycle pulses.
interface qspi_arb_if #(
    parameter int TW = 22
) ();
    logic          d_req;
    logic          d_write;
    logic          d_lock;
    logic [TW-1:0] d_tag;
    logic          i_req;
    logic [TW-1:0] i_tag;
    logic          x_req;
    logic          x_write;
    logic [TW-1:0] x_tag;
    logic [1:0]    rom_mode;
    logic          q_done;

    logic          d_grant;
    logic          i_grant;
    logic          x_grant;
    logic          d_done;
    logic          i_done;
    logic          x_done;
    logic          err;
    logic          q_req;
    logic          q_write;
    logic          q_i_d;
    logic [1:0]    q_mem;
    logic [TW-1:0] q_paddr;
    logic [1:0]    fsm_state;

    modport slave (
        input  d_req, d_write, d_lock, d_tag, i_req, i_tag,
               x_req, x_write, x_tag, rom_mode, q_done,
        output d_grant, i_grant, x_grant, d_done, i_done, x_done,
               err, q_req, q_write, q_i_d, q_mem, q_paddr, fsm_state
    );

    modport master (
        output d_req, d_write, d_lock, d_tag, i_req, i_tag,
               x_req, x_write, x_tag, rom_mode, q_done,
        input  d_grant, i_grant, x_grant, d_done, i_done, x_done,
               err, q_req, q_write, q_i_d, q_mem, q_paddr, fsm_state
    );
endinterface

// File: rtl/qspi_arb.sv
// Three-way line-transfer arbiter in front of a QSPI engine: fixed d>i>x priority with
// starvation promotion for i/x, optional dcache lock, and a per-transfer timeout.
module qspi_arb #(
    parameter int PA          = 24,
    parameter int LINE_LENGTH = 4,
    parameter int STARVE      = 4,
    parameter int TIMEOUT     = 255
) (
    input logic       clk,
    input logic       reset,
    qspi_arb_if.slave bus
);
    localparam int TW = PA - $clog2(LINE_LENGTH);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {W_D = 2'd0, W_I = 2'd1, W_X = 2'd2} who_t;

    state_t        state_q, state_d;
    who_t          who_q, win;
    logic          win_valid;
    logic          write_q;
    logic [TW-1:0] tag_q;
    logic          err_q;
    logic          lock_q;
    logic [2:0]    i_starve_q, x_starve_q;
    logic [7:0]    tmo_q;
    logic          i_starved, x_starved, timeout, xfer, done_st;
    logic [1:0]    mem_sel;

    assign i_starved = (i_starve_q == 3'(STARVE));
    assign x_starved = (x_starve_q == 3'(STARVE));
    assign timeout   = (tmo_q == 8'(TIMEOUT - 1));

    // A pending lock restricts the arbitration to the dcache alone.
    always_comb begin
        win_valid = 1'b0;
        win       = W_D;
        if (lock_q) begin
            win_valid = bus.d_req;
        end else if (bus.i_req && i_starved) begin
            win_valid = 1'b1;
            win       = W_I;
        end else if (bus.x_req && x_starved) begin
            win_valid = 1'b1;
            win       = W_X;
        end else if (bus.d_req) begin
            win_valid = 1'b1;
        end else if (bus.i_req) begin
            win_valid = 1'b1;
            win       = W_I;
        end else if (bus.x_req) begin
            win_valid = 1'b1;
            win       = W_X;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = XFER;
            XFER:    if (bus.q_done || timeout) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            who_q      <= W_D;
            write_q    <= 1'b0;
            tag_q      <= '0;
            err_q      <= 1'b0;
            lock_q     <= 1'b0;
            i_starve_q <= 3'd0;
            x_starve_q <= 3'd0;
            tmo_q      <= 8'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        who_q  <= win;
                        tmo_q  <= 8'd0;
                        lock_q <= (win == W_D) && bus.d_lock;
                        case (win)
                            W_I: begin
                                tag_q   <= bus.i_tag;
                                write_q <= 1'b0;
                            end
                            W_X: begin
                                tag_q   <= bus.x_tag;
                                write_q <= bus.x_write;
                            end
                            default: begin
                                tag_q   <= bus.d_tag;
                                write_q <= bus.d_write;
                            end
                        endcase
                        if (win == W_I)
                            i_starve_q <= 3'd0;
                        else if (bus.i_req && !lock_q && !i_starved)
                            i_starve_q <= i_starve_q + 3'd1;
                        if (win == W_X)
                            x_starve_q <= 3'd0;
                        else if (bus.x_req && !lock_q && !x_starved)
                            x_starve_q <= x_starve_q + 3'd1;
                    end else begin
                        // Locked but dcache did not come back: give the lock up.
                        lock_q <= 1'b0;
                    end
                end
                XFER: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (state_d == DONE) err_q <= !bus.q_done;
                end
                default: ;
            endcase
        end
    end

    assign xfer    = (state_q == XFER);
    assign done_st = (state_q == DONE);

    always_comb begin
        mem_sel = 2'd0;
        if (xfer) begin
            case (bus.rom_mode)
                2'b00:   mem_sel = tag_q[TW-1] ? 2'd2 : 2'd0;
                2'b01:   mem_sel = 2'd0;
                2'b10:   mem_sel = tag_q[TW-1] ? 2'd1 : 2'd0;
                default: mem_sel = (who_q == W_I || !write_q) ? 2'd1 : 2'd0;
            endcase
        end
    end

    assign bus.d_grant   = xfer && (who_q == W_D);
    assign bus.i_grant   = xfer && (who_q == W_I);
    assign bus.x_grant   = xfer && (who_q == W_X);
    assign bus.d_done    = done_st && (who_q == W_D);
    assign bus.i_done    = done_st && (who_q == W_I);
    assign bus.x_done    = done_st && (who_q == W_X);
    assign bus.err       = done_st && err_q;
    assign bus.q_req     = xfer;
    assign bus.q_write   = xfer && write_q;
    assign bus.q_i_d     = xfer && (who_q == W_I);
    assign bus.q_mem     = mem_sel;
    assign bus.q_paddr   = xfer ? tag_q : '0;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb: priority, starvation, lock, timeout, rom_mode decode and reset.
module tb_qspi_arb;
  localparam int TW = 22;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  qspi_arb_if #(.TW(TW)) bus ();

  qspi_arb #(.PA(24), .LINE_LENGTH(4), .STARVE(4), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {d_grant,i_grant,x_grant,d_done,i_done,x_done,err,q_req,q_write,q_i_d}
  function automatic logic [9:0] flags();
    return {bus.d_grant, bus.i_grant, bus.x_grant, bus.d_done, bus.i_done,
            bus.x_done, bus.err, bus.q_req, bus.q_write, bus.q_i_d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.d_req = 0; bus.d_write = 0; bus.d_lock = 0; bus.d_tag = '0;
    bus.i_req = 0; bus.i_tag = '0;
    bus.x_req = 0; bus.x_write = 0; bus.x_tag = '0;
    bus.q_done = 0;
  endtask

  // Pulse q_done for one cycle; returns in the DONE cycle.
  task automatic finish_xfer();
    bus.q_done = 1;
    step();
    bus.q_done = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.rom_mode = 2'b01;
    #2 reset = 0;
    #1;
    tests++; if (flags() !== 10'b0) begin fails++; $display("FAIL reset_flags: got %b want 0", flags()); end
    tests++; if (bus.q_mem !== 2'd0) begin fails++; $display("FAIL reset_q_mem: got %0d want 0", bus.q_mem); end
    tests++; if (bus.q_paddr !== '0) begin fails++; $display("FAIL reset_q_paddr: got %h want 0", bus.q_paddr); end
    tests++; if (bus.fsm_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.fsm_state); end
    repeat (2) @(posedge clk);
    #1 reset = 1;
    step();
    tests++; if (flags() !== 10'b0) begin fails++; $display("FAIL idle_no_req: got %b want 0", flags()); end
  endtask

  task automatic test_priority();
    bus.d_tag = 22'h2AAAAA; bus.i_tag = 22'h155555; bus.x_tag = 22'h0F0F0F;
    bus.d_req = 1; bus.i_req = 1; bus.x_req = 1;
    step();
    tests++; if (flags() !== 10'b1000000100) begin fails++; $display("FAIL prio_d_grant: got %b want 1000000100", flags()); end
    tests++; if (bus.q_paddr !== 22'h2AAAAA) begin fails++; $display("FAIL prio_d_paddr: got %h want 2aaaaa", bus.q_paddr); end
    bus.d_req = 0;
    finish_xfer();
    tests++; if (flags() !== 10'b0001000000) begin fails++; $display("FAIL prio_d_done: got %b want 0001000000", flags()); end
    step();
    tests++; if (flags() !== 10'b0) begin fails++; $display("FAIL prio_gap: got %b want 0", flags()); end
    step();
    tests++; if (flags() !== 10'b0100000101) begin fails++; $display("FAIL prio_i_grant: got %b want 0100000101", flags()); end
    tests++; if (bus.q_paddr !== 22'h155555) begin fails++; $display("FAIL prio_i_paddr: got %h want 155555", bus.q_paddr); end
    bus.i_req = 0;
    finish_xfer();
    tests++; if (flags() !== 10'b0000100000) begin fails++; $display("FAIL prio_i_done: got %b want 0000100000", flags()); end
    step();
    step();
    tests++; if (flags() !== 10'b0010000100) begin fails++; $display("FAIL prio_x_grant: got %b want 0010000100", flags()); end
    tests++; if (bus.q_paddr !== 22'h0F0F0F) begin fails++; $display("FAIL prio_x_paddr: got %h want 0f0f0f", bus.q_paddr); end
    bus.x_req = 0;
    finish_xfer();
    tests++; if (flags() !== 10'b0000010000) begin fails++; $display("FAIL prio_x_done: got %b want 0000010000", flags()); end
    step();
  endtask

  task automatic test_spurious_done();
    clear_inputs();
    bus.q_done = 1;
    step();
    bus.q_done = 0;
    tests++; if (bus.fsm_state !== 2'd0) begin fails++; $display("FAIL spurious_state: got %0d want 0", bus.fsm_state); end
    step();
    tests++; if (flags() !== 10'b0) begin fails++; $display("FAIL spurious_flags: got %b want 0", flags()); end
  endtask

  task automatic test_starve(input bit use_x);
    logic exp_d;
    logic got_other;
    clear_inputs();
    bus.d_req = 1;
    if (use_x) bus.x_req = 1; else bus.i_req = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_d = (k <= 4);
      got_other = use_x ? bus.x_grant : bus.i_grant;
      tests++;
      if (bus.d_grant !== exp_d || got_other !== !exp_d) begin
        fails++;
        $display("FAIL starve_%s_arb%0d: got d=%b other=%b want d=%b other=%b",
                 use_x ? "x" : "i", k, bus.d_grant, got_other, exp_d, !exp_d);
      end
      finish_xfer();
      step();
      if (k == 5) clear_inputs();
    end
  endtask

  task automatic test_lock();
    clear_inputs();
    bus.d_req = 1; bus.d_write = 1; bus.d_lock = 1; bus.i_req = 1;
    step();
    tests++; if (flags() !== 10'b1000000110) begin fails++; $display("FAIL lock_push: got %b want 1000000110", flags()); end
    bus.d_write = 0; bus.d_lock = 0;
    finish_xfer();
    step();
    step();
    tests++; if (flags() !== 10'b1000000100) begin fails++; $display("FAIL lock_pull: got %b want 1000000100", flags()); end
    bus.d_req = 0;
    finish_xfer();
    step();
    step();
    tests++; if (bus.i_grant !== 1'b1) begin fails++; $display("FAIL lock_release_i: got %b want 1", bus.i_grant); end
    finish_xfer();
    step();
    // Lock given up by an idle cycle with d_req low.
    clear_inputs();
    bus.d_req = 1; bus.d_lock = 1; bus.i_req = 1;
    step();
    tests++; if (bus.d_grant !== 1'b1) begin fails++; $display("FAIL lock2_d: got %b want 1", bus.d_grant); end
    bus.d_req = 0; bus.d_lock = 0;
    finish_xfer();
    step();
    step();
    tests++; if (flags() !== 10'b0) begin fails++; $display("FAIL lock2_hold: got %b want 0", flags()); end
    step();
    tests++; if (bus.i_grant !== 1'b1) begin fails++; $display("FAIL lock2_i: got %b want 1", bus.i_grant); end
    bus.i_req = 0;
    finish_xfer();
    step();
  endtask

  task automatic test_timeout();
    int bad;
    clear_inputs();
    bus.i_req = 1;
    step();
    tests++; if (bus.i_grant !== 1'b1) begin fails++; $display("FAIL tmo_grant: got %b want 1", bus.i_grant); end
    bus.i_req = 0;
    bad = 0;
    repeat (254) begin
      step();
      if (flags() !== 10'b0100000101) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL tmo_hold: got %0d bad cycles want 0", bad); end
    step();
    tests++; if (flags() !== 10'b0000101000) begin fails++; $display("FAIL tmo_err: got %b want 0000101000", flags()); end
    step();
    tests++; if (bus.fsm_state !== 2'd0 || flags() !== 10'b0) begin fails++; $display("FAIL tmo_idle: got state=%0d flags=%b want 0/0", bus.fsm_state, flags()); end
    // q_done lands in the last allowed cycle: normal completion.
    bus.i_req = 1;
    step();
    bus.i_req = 0;
    repeat (254) step();
    bus.q_done = 1;
    step();
    bus.q_done = 0;
    tests++; if (flags() !== 10'b0000100000) begin fails++; $display("FAIL tmo_edge_done: got %b want 0000100000", flags()); end
    step();
  endtask

  task automatic test_rom_mode();
    clear_inputs();
    bus.rom_mode = 2'b10;
    bus.x_tag = 22'h200001; bus.x_req = 1;
    step();
    tests++; if (bus.q_mem !== 2'd1) begin fails++; $display("FAIL rom10_x: got %0d want 1", bus.q_mem); end
    bus.rom_mode = 2'b00;
    #1;
    tests++; if (bus.q_mem !== 2'd2) begin fails++; $display("FAIL rom00_live: got %0d want 2", bus.q_mem); end
    bus.x_req = 0;
    finish_xfer();
    step();
    bus.rom_mode = 2'b11;
    bus.d_req = 1; bus.d_write = 1; bus.d_tag = 22'h3FFFFF;
    step();
    tests++; if (bus.q_mem !== 2'd0 || bus.q_write !== 1'b1) begin fails++; $display("FAIL rom11_dwrite: got mem=%0d wr=%b want 0/1", bus.q_mem, bus.q_write); end
    bus.d_req = 0; bus.d_write = 0;
    finish_xfer();
    step();
    bus.i_req = 1; bus.i_tag = 22'h000010;
    step();
    tests++; if (bus.q_i_d !== 1'b1 || bus.q_mem !== 2'd1) begin fails++; $display("FAIL rom11_i: got iid=%b mem=%0d want 1/1", bus.q_i_d, bus.q_mem); end
    bus.i_req = 0;
    finish_xfer();
    step();
  endtask

  task automatic test_reset_mid_xfer();
    clear_inputs();
    bus.rom_mode = 2'b11;
    bus.d_req = 1; bus.d_tag = 22'h123456;
    step();
    tests++; if (bus.d_grant !== 1'b1 || bus.q_mem !== 2'd1) begin fails++; $display("FAIL rst_pre_grant: got g=%b mem=%0d want 1/1", bus.d_grant, bus.q_mem); end
    bus.d_req = 0; bus.i_req = 1; bus.i_tag = 22'h0ABCDE;
    #2 reset = 0;
    #1;
    tests++; if (flags() !== 10'b0 || bus.q_mem !== 2'd0 || bus.q_paddr !== '0) begin fails++; $display("FAIL rst_async: got flags=%b mem=%0d paddr=%h want 0", flags(), bus.q_mem, bus.q_paddr); end
    bus.q_done = 1;
    @(posedge clk);
    #1;
    bus.q_done = 0;
    tests++; if (flags() !== 10'b0) begin fails++; $display("FAIL rst_no_done: got %b want 0", flags()); end
    reset = 1;
    step();
    tests++; if (bus.i_grant !== 1'b1 || bus.q_paddr !== 22'h0ABCDE) begin fails++; $display("FAIL rst_i_grant: got g=%b paddr=%h want 1/0abcde", bus.i_grant, bus.q_paddr); end
    bus.i_req = 0;
    finish_xfer();
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_spurious_done();
    test_starve(1'b0);
    test_starve(1'b1);
    test_lock();
    test_timeout();
    test_rom_mode();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/qspi_arb.md
QSPI_ARB -- requirements
Module: qspi_arb

Interface
REQ-001 Parameter PA, default 24, physical address width in bits.
REQ-002 Parameter LINE_LENGTH, default 4, cache line length in bytes; tag width TW = PA-clog2(LINE_LENGTH).
REQ-003 Parameter STARVE, default 4, lost arbitrations before a requester is promoted (range 1..7).
REQ-004 Parameter TIMEOUT, default 255, cycles allowed per line transfer (range 1..255).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 d_req, d_write, d_lock  input  1 each  dcache line request, 1=push (write), hold grant for the following transfer.
REQ-008 d_tag  input  TW  dcache line tag.
REQ-009 i_req  input  1; i_tag  input  TW  icache line-fill request, always a read.
REQ-010 x_req, x_write  input  1 each; x_tag  input  TW  auxiliary (boot/DMA) requester.
REQ-011 rom_mode  input  2  memory-map mode from the QSPI register block.
REQ-012 q_done  input  1  one-cycle pulse from the QSPI engine at end of a line transfer.
REQ-013 d_grant, i_grant, x_grant  output  1 each  requester owns the QSPI port.
REQ-014 d_done, i_done, x_done  output  1 each  one-cycle transfer-complete pulse.
REQ-015 err  output  1  one-cycle pulse coincident with a done pulse when the transfer timed out.
REQ-016 q_req, q_write, q_i_d  output  1 each  to QSPI: request, write, instruction-side.
REQ-017 q_mem  output  2  chip select index; q_paddr  output  TW  line tag.

Function
REQ-018 FSM states IDLE, XFER, DONE; IDLE->XFER when an eligible request exists; XFER->DONE on q_done or timeout; DONE->IDLE unconditionally.
REQ-019 In IDLE: arbitration is combinational on the requests present; winner's tag, write flag and identity are registered on the IDLE->XFER edge.
REQ-020 Base priority d > i > x; a requester whose starve counter equals STARVE outranks base priority; i beats x if both starved; d is never starved-promoted.
REQ-021 i and x each have a 3-bit starve counter: +1 per arbitration they request and lose (saturating at STARVE), cleared when granted.
REQ-022 In XFER: the winner's grant is 1, q_req=1, q_write/q_paddr from registered values, q_i_d=1 only for i, q_mem per REQ-023; all held constant throughout.
REQ-023 q_mem: rom_mode 00 -> tag MSB ? 2 : 0; 01 -> 0; 10 -> tag MSB ? 1 : 0; 11 -> (q_i_d or not q_write) ? 1 : 0; rom_mode sampled live.
REQ-024 In DONE: grants 0, q_req 0, winner's done pulses 1 cycle; err also 1 if exit was by timeout.
REQ-025 Latency: request in IDLE -> grant and q_req next cycle; q_done -> done next cycle; minimum 3 cycles between successive grants.
REQ-026 An 8-bit timeout counter clears on entry to XFER, increments each XFER cycle; reaching TIMEOUT without q_done exits to DONE with err.
REQ-027 q_done and timeout in the same cycle: treated as normal completion, err=0.
REQ-028 q_done outside XFER is ignored.
REQ-029 Requester dropping req during XFER does not abort; transfer completes and done still pulses.
REQ-030 d_lock sampled at XFER entry: if 1, the next IDLE arbitration considers d only (i/x counters not incremented); lock consumed after that one arbitration or after one IDLE cycle with d_req low.
REQ-031 At most one grant and one done asserted in any cycle.

Reset
REQ-032 reset low: immediately state IDLE, all grants/dones/err/q_req/q_write/q_i_d 0, q_mem 0, q_paddr 0, starve counters 0, timeout counter 0, lock clear.
REQ-033 Reset during XFER abandons the transfer with no done pulse; first arbitration occurs in the first cycle after reset release.

Verification
REQ-034 d_req, i_req, x_req all high in IDLE -> d_grant next cycle, q_paddr=d_tag; q_done -> d_done next cycle; i then x served in later arbitrations.
REQ-035 d_req held continuously with i_req high, STARVE=4 -> i loses 4 times, 5th arbitration grants i despite d_req.
REQ-036 d_req, d_write=1, d_lock=1, i_req high -> push, then next grant is d (pull, d_write=0), not i.
REQ-037 i_req, no q_done, TIMEOUT=255 -> i_done and err high together in cycle 256 after grant, then IDLE.
REQ-038 rom_mode=10, x_tag MSB=1 -> q_mem=1; rom_mode=11, d_write=1 -> q_mem=0; i_req -> q_i_d=1, q_mem=1.
REQ-039 reset asserted mid-XFER -> all outputs 0 same cycle, no done; after release pending i_req granted next cycle.
